// File: rtl/wca_iq_packer.sv
// wca_iq_packer: pairs interleaved I/Q samples into 32-bit words
// and queues them in a small first-word-fall-through FIFO.
//
// Ports:
//   clock, reset      sole clock; async active-high reset
//   enable            packer enable (low: no capture, no push)
//   strobe, iqSel     sample-valid qualifier; 0 = I, 1 = Q
//   sig_in[11:0]      signed sample, left-justified to 16 bits
//   clear_status      sync clear of overflow and both counters
//   out_ready         downstream accepts out_data
//   out_valid         out_data holds a valid pair
//   out_data[31:0]    {Q[15:0], I[15:0]}
//   fifo_level        pairs currently held
//   overflow          sticky: a pair was dropped (FIFO full)
//   drop_count        dropped pairs, saturating
//   misalign_count    I/Q sequence violations, saturating
module wca_iq_packer #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  strobe,
    input  logic                  iqSel,
    input  logic [11:0]           sig_in,
    input  logic                  clear_status,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [31:0]           out_data,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  overflow,
    output logic [15:0]           drop_count,
    output logic [15:0]           misalign_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL =
        {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [0:0] WAIT_I = 1'b0;
    localparam logic [0:0] WAIT_Q = 1'b1;

    // Reset release is retimed by one flop: the edge right after
    // deassertion is ignored, so capture starts on the second edge.
    logic rst_q;
    logic active;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_q <= 1'b1;
        end else begin
            rst_q <= 1'b0;
        end
    end

    assign active = ~rst_q;

    logic [0:0]  state;
    logic [15:0] hold_i;
    logic [15:0] sample;
    logic        take;
    logic        push;
    logic        misalign;

    assign sample = {sig_in, 4'b0000};
    assign take   = active & enable & strobe;

    always_comb begin
        push     = 1'b0;
        misalign = 1'b0;
        if (take) begin
            case (state)
                WAIT_I: misalign = iqSel;
                WAIT_Q: begin
                    push     = iqSel;
                    misalign = ~iqSel;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= WAIT_I;
            hold_i <= 16'd0;
        end else if (!enable) begin
            state  <= WAIT_I;
            hold_i <= 16'd0;
        end else if (take) begin
            case (state)
                WAIT_I: begin
                    if (!iqSel) begin
                        hold_i <= sample;
                        state  <= WAIT_Q;
                    end
                end
                WAIT_Q: begin
                    // A repeated I replaces the held one.
                    if (iqSel) begin
                        state <= WAIT_I;
                    end else begin
                        hold_i <= sample;
                    end
                end
                default: state <= WAIT_I;
            endcase
        end
    end

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic                  pop;
    logic                  full;
    logic                  accept;
    logic                  drop;

    assign out_valid = (fifo_level != '0);
    assign pop       = out_valid & out_ready;
    assign full      = (fifo_level == LVL_FULL);
    // A pop in the same cycle frees the slot the push needs.
    assign accept    = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign out_data  = out_valid ? mem[rptr] : 32'd0;

    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wptr] <= {sample, hold_i};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
        end else begin
            if (accept) begin
                wptr <= wptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rptr <= rptr + DEPTH_LOG2'(1);
            end
            case ({accept, pop})
                2'b10:   fifo_level <= fifo_level + (DEPTH_LOG2+1)'(1);
                2'b01:   fifo_level <= fifo_level - (DEPTH_LOG2+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow       <= 1'b0;
            drop_count     <= 16'd0;
            misalign_count <= 16'd0;
        end else if (clear_status) begin
            overflow       <= 1'b0;
            drop_count     <= 16'd0;
            misalign_count <= 16'd0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (drop && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
            if (misalign && misalign_count != 16'hFFFF) begin
                misalign_count <= misalign_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_wca_iq_packer.sv
// tb_wca_iq_packer: directed and randomized checks of wca_iq_packer
// against a queue-based pairing model.
module tb_wca_iq_packer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        strobe = 1'b0;
    logic        iqSel = 1'b0;
    logic [11:0] sig_in = 12'd0;
    logic        clear_status = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [15:0] drop_count;
    logic [15:0] misalign_count;

    int tests_run = 0;
    int tests_failed = 0;

    wca_iq_packer #(.DEPTH_LOG2(2)) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .strobe(strobe),
        .iqSel(iqSel),
        .sig_in(sig_in),
        .clear_status(clear_status),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .fifo_level(fifo_level),
        .overflow(overflow),
        .drop_count(drop_count),
        .misalign_count(misalign_count)
    );

    always #5 clock = ~clock;

    // Reference model: a queue of pairs, an optional pending I,
    // and plain integer counters clipped at 65535.
    logic [31:0] m_q[$];
    bit          m_have_i;
    logic [15:0] m_i;
    bit          m_ovf;
    int          m_drop;
    int          m_mis;
    bit          m_guard;

    task automatic model_clear();
        m_q.delete();
        m_have_i = 0;
        m_i      = 16'd0;
        m_ovf    = 0;
        m_drop   = 0;
        m_mis    = 0;
        m_guard  = 1;
    endtask

    task automatic step();
        bit act;
        bit mis_ev;
        bit drop_ev;
        logic [15:0] s;
        act     = !m_guard;
        m_guard = 0;
        mis_ev  = 0;
        drop_ev = 0;
        s       = {sig_in, 4'h0};
        if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
        if (!enable) begin
            m_have_i = 0;
        end else if (act && strobe) begin
            if (!iqSel) begin
                if (m_have_i) mis_ev = 1;
                m_have_i = 1;
                m_i = s;
            end else if (m_have_i) begin
                m_have_i = 0;
                if (m_q.size() < 4) m_q.push_back({s, m_i});
                else drop_ev = 1;
            end else begin
                mis_ev = 1;
            end
        end
        if (clear_status) begin
            m_ovf = 0;
            m_drop = 0;
            m_mis = 0;
        end else begin
            if (drop_ev) m_ovf = 1;
            if (drop_ev && m_drop < 65535) m_drop++;
            if (mis_ev && m_mis < 65535) m_mis++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        strobe = 1'b0;
        clear_status = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1'b1;
        model_clear();
        #2;
        @(posedge clock);
        #1;
        reset = 1'b0;
        step();
    endtask

    task automatic send(input bit q, input logic [11:0] v);
        strobe = 1'b1;
        iqSel  = q;
        sig_in = v;
        step();
        strobe = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        out_ready = 1'b0;
        send(1'b1, 12'h111);
        send(1'b0, 12'h222);
        send(1'b1, 12'h333);
        tests_run++;
        if (out_valid !== 1'b1 || misalign_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL pre_reset: valid=%b mis=%0d req 1/1",
                     out_valid, misalign_count);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({out_valid, fifo_level, out_data} !== 36'd0) begin
            tests_failed++;
            $display("FAIL async_reset_fifo: v=%b l=%0d d=%h req 0",
                     out_valid, fifo_level, out_data);
        end
        tests_run++;
        if ({overflow, drop_count, misalign_count} !== 33'd0) begin
            tests_failed++;
            $display("FAIL async_reset_stat: o=%b d=%0d m=%0d req 0",
                     overflow, drop_count, misalign_count);
        end
        model_clear();
        @(posedge clock);
        #1;
        reset = 1'b0;
        step();
    endtask

    task automatic test_sync_release();
        apply_reset();
        reset = 1'b1;
        model_clear();
        #2;
        @(posedge clock);
        #1;
        reset = 1'b0;
        enable = 1'b1;
        out_ready = 1'b1;
        send(1'b0, 12'h0AA);
        send(1'b1, 12'h0BB);
        tests_run++;
        if (out_valid !== 1'b0 || misalign_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL sync_release: valid=%b mis=%0d req 0/1",
                     out_valid, misalign_count);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        send(1'b0, 12'h123);
        send(1'b1, 12'hF00);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hF000_1230) begin
            tests_failed++;
            $display("FAIL basic_pair: v=%b d=%h req 1 f0001230",
                     out_valid, out_data);
        end
        step();
        tests_run++;
        if (fifo_level !== 3'd0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_pop: lvl=%0d v=%b req 0 0",
                     fifo_level, out_valid);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp [5];
        logic [11:0] iv;
        logic [11:0] qv;
        apply_reset();
        enable = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            iv = 12'($urandom);
            qv = 12'($urandom);
            exp[k] = {qv, 4'h0, iv, 4'h0};
            send(1'b0, iv);
            send(1'b1, qv);
        end
        tests_run++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1 ||
            drop_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL overflow: l=%0d o=%b d=%0d req 4 1 1",
                     fifo_level, overflow, drop_count);
        end
        step();
        tests_run++;
        if (out_data !== exp[0]) begin
            tests_failed++;
            $display("FAIL hold_stable: d=%h req %h", out_data, exp[0]);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (out_data !== exp[k] || out_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL drain_%0d: d=%h req %h", k, out_data,
                         exp[k]);
            end
            step();
        end
        tests_run++;
        if (fifo_level !== 3'd0) begin
            tests_failed++;
            $display("FAIL drain_empty: l=%0d req 0", fifo_level);
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] exp [5];
        logic [11:0] iv;
        logic [11:0] qv;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            iv = 12'($urandom);
            qv = 12'($urandom);
            exp[k] = {qv, 4'h0, iv, 4'h0};
            send(1'b0, iv);
            if (k == 4) out_ready = 1'b1;
            send(1'b1, qv);
        end
        tests_run++;
        if (fifo_level !== 3'd4 || drop_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL full_pop: l=%0d d=%0d req 4 1",
                     fifo_level, drop_count);
        end
        for (int k = 1; k < 5; k++) begin
            tests_run++;
            if (out_data !== exp[k]) begin
                tests_failed++;
                $display("FAIL full_pop_order_%0d: d=%h req %h", k,
                         out_data, exp[k]);
            end
            step();
        end
    endtask

    task automatic test_misalign();
        apply_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        send(1'b1, 12'h7AB);
        send(1'b0, 12'h010);
        send(1'b0, 12'h020);
        send(1'b1, 12'h030);
        tests_run++;
        if (out_data !== 32'h0300_0200 || misalign_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL misalign: d=%h m=%0d req 03000200 2",
                     out_data, misalign_count);
        end
        step();
    endtask

    task automatic test_enable_low();
        apply_reset();
        enable = 1'b1;
        out_ready = 1'b0;
        send(1'b0, 12'h055);
        enable = 1'b0;
        step();
        enable = 1'b1;
        send(1'b1, 12'h066);
        tests_run++;
        if (out_valid !== 1'b0 || misalign_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL enable_low: v=%b m=%0d req 0 1",
                     out_valid, misalign_count);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        send(1'b0, 12'h321);
        reset = 1'b1;
        model_clear();
        #2;
        reset = 1'b0;
        step();
        send(1'b1, 12'h654);
        tests_run++;
        if (out_valid !== 1'b0 || misalign_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL reset_mid: v=%b m=%0d req 0 1",
                     out_valid, misalign_count);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        enable = 1'b1;
        out_ready = 1'b1;
        strobe = 1'b1;
        iqSel = 1'b1;
        for (int k = 0; k < 70000; k++) step();
        tests_run++;
        if (misalign_count !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL saturate: m=%h req ffff", misalign_count);
        end
        clear_status = 1'b1;
        step();
        tests_run++;
        if (misalign_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL clear_prio: m=%h req 0", misalign_count);
        end
        clear_status = 1'b0;
        step();
        tests_run++;
        if (misalign_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL after_clear: m=%h req 1", misalign_count);
        end
        strobe = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] ed;
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            enable = ($urandom_range(0, 15) != 0);
            strobe = $urandom_range(0, 1);
            iqSel = $urandom_range(0, 1);
            sig_in = 12'($urandom);
            clear_status = ($urandom_range(0, 40) == 0);
            out_ready = (c < 400) ? ($urandom_range(0, 3) == 0)
                                  : ($urandom_range(0, 2) != 0);
            step();
            ed = (m_q.size() > 0) ? m_q[0] : 32'd0;
            tests_run++;
            if (out_valid !== (m_q.size() > 0) || out_data !== ed ||
                fifo_level !== 3'(m_q.size())) begin
                tests_failed++;
                $display("FAIL rnd_fifo c%0d: v=%b d=%h l=%0d req %h l%0d",
                         c, out_valid, out_data, fifo_level, ed,
                         m_q.size());
            end
            tests_run++;
            if (overflow !== m_ovf || drop_count !== 16'(m_drop) ||
                misalign_count !== 16'(m_mis)) begin
                tests_failed++;
                $display("FAIL rnd_stat c%0d: o=%b d=%0d m=%0d req %b %0d %0d",
                         c, overflow, drop_count, misalign_count,
                         m_ovf, m_drop, m_mis);
            end
        end
        idle();
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        step();
        test_reset();
        test_sync_release();
        test_basic();
        test_overflow();
        test_full_pop();
        test_misalign();
        test_enable_low();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run,
                 tests_failed);
        $finish;
    end

endmodule
